// File: rtl/clk_div_mc.sv
// Multi-channel programmable clock divider with glitch-free ratio reload and per-channel
// reset-release flags. Define CLK_DIV_MC_ODD50_EN for 50% duty on odd ratios.
module clk_div_mc #(
    parameter int unsigned NCH         = 2,
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 13,
    parameter int unsigned RST_CYC     = 7
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic [NCH-1:0]         en,
    input  logic [NCH*DIV_W-1:0]   div_cfg,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    output logic [NCH-1:0]         clk_out,
    output logic [NCH-1:0]         tick,
    output logic [NCH-1:0]         rst_out,
    output logic                   clk_cpy
);

    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
    localparam logic [DIV_W-1:0] MIN_N    = DIV_W'(2);
    localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DEF_LAST = ((DEF_DIV < MIN_N) ? MIN_N : DEF_DIV) - ONE;
    localparam int unsigned      RW       = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    typedef enum logic [1:0] {StPark, StRun, StPend} ch_st_e;

    logic                 xfer;
    logic [NCH-1:0]       pend;
    logic [NCH*DIV_W-1:0] shadow_q;

    assign xfer      = cfg_valid & cfg_ready;
    assign cfg_ready = ~|pend;
    assign clk_cpy   = clk_in;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            shadow_q <= {NCH{DEF_DIV}};
        end else if (xfer) begin
            shadow_q <= div_cfg;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        ch_st_e           st_q, st_d;
        logic [DIV_W-1:0] div_q, div_d, c_q, c_d;
        logic [DIV_W-1:0] shad, n_cur, n_new, n_eff;
        logic             p_q, p_d, tick_q, tick_d, rdy_q, rdy_d;
        logic [RW-1:0]    cnt_q, cnt_d;
        logic             at_end, load;

        assign shad    = shadow_q[k*DIV_W +: DIV_W];
        assign n_cur   = (div_q < MIN_N) ? MIN_N : div_q;
        assign n_new   = (shad < MIN_N) ? MIN_N : shad;
        assign at_end  = (c_q == n_cur - ONE);
        // A pending ratio is taken at the period boundary, whether wrapping or parked.
        assign load    = (st_q == StPend) && at_end;
        assign pend[k] = (st_q == StPend);

        always_comb begin
            st_d = st_q;
            unique case (st_q)
                StPark:  if (xfer) st_d = StPend; else if (en[k]) st_d = StRun;
                StRun:   if (xfer) st_d = StPend; else if (at_end && !en[k]) st_d = StPark;
                StPend:  if (at_end) st_d = en[k] ? StRun : StPark;
                default: st_d = StPark;
            endcase
        end

        always_comb begin
            div_d = div_q;
            n_eff = n_cur;
            if (load) begin
                div_d = shad;
                n_eff = n_new;
            end
            if (at_end) c_d = en[k] ? '0 : n_eff - ONE;
            else        c_d = c_q + ONE;
            p_d    = (c_d < (n_eff >> 1));
            tick_d = en[k] & at_end;
            cnt_d  = cnt_q;
            rdy_d  = rdy_q;
            if (tick_q && !rdy_q) begin
                if (cnt_q == RW'(RST_CYC - 1)) rdy_d = 1'b1;
                else                           cnt_d = cnt_q + RW'(1);
            end
        end

        always_ff @(posedge clk_in or negedge rst) begin
            if (!rst) begin
                st_q   <= StPark;
                div_q  <= DEF_DIV;
                c_q    <= DEF_LAST;
                p_q    <= 1'b0;
                tick_q <= 1'b0;
                cnt_q  <= '0;
                rdy_q  <= 1'b0;
            end else begin
                st_q   <= st_d;
                div_q  <= div_d;
                c_q    <= c_d;
                p_q    <= p_d;
                tick_q <= tick_d;
                cnt_q  <= cnt_d;
                rdy_q  <= rdy_d;
            end
        end

`ifdef CLK_DIV_MC_ODD50_EN
        // Half-cycle extension of the high phase for odd ratios.
        logic pn_q;
        always_ff @(negedge clk_in or negedge rst) begin
            if (!rst) pn_q <= 1'b0;
            else      pn_q <= p_q & n_cur[0];
        end
        assign clk_out[k] = p_q | pn_q;
`else
        assign clk_out[k] = p_q;
`endif
        assign tick[k]    = tick_q;
        assign rst_out[k] = rdy_q;
    end

endmodule

// File: tb/tb_clk_div_mc.sv
// Directed bench for clk_div_mc: default ratio, reconfiguration, divide-by-2, enable
// park/restart, async reset mid-run and odd-ratio duty.
module tb_clk_div_mc;

`ifdef CLK_DIV_MC_ODD50_EN
    localparam int H13 = 7;
    localparam int H7  = 4;
    localparam int H5  = 3;
`else
    localparam int H13 = 6;
    localparam int H7  = 3;
    localparam int H5  = 2;
`endif

    logic        clk_in;
    logic        rst;
    logic [1:0]  en;
    logic [15:0] div_cfg;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  clk_out;
    logic [1:0]  tick;
    logic [1:0]  rst_out;
    logic        clk_cpy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int a, b3;

    clk_div_mc dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
        .div_cfg   (div_cfg),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .rst_out   (rst_out),
        .clk_cpy   (clk_cpy)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic step();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic chk_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // n==0 means the channel is expected parked (low, no tick).
    task automatic cyc_chk(input int n0, input int h0, input int b0,
                           input int n1, input int h1, input int b1,
                           input logic [1:0] xr, input logic xrdy);
        logic [1:0] xc, xt;
        int r;
        xc = '0;
        xt = '0;
        if (n0 != 0) begin
            r = (cyc - b0) % n0;
            xc[0] = (r < h0);
            xt[0] = (r == 0);
        end
        if (n1 != 0) begin
            r = (cyc - b1) % n1;
            xc[1] = (r < h1);
            xt[1] = (r == 0);
        end
        chk_v("clk_out", clk_out, xc);
        chk_v("tick", tick, xt);
        chk_v("rst_out", rst_out, xr);
        chk_v("cfg_ready", cfg_ready, xrdy);
    endtask

    task automatic run(input int cnt, input int n0, input int h0, input int b0,
                       input int n1, input int h1, input int b1,
                       input logic [1:0] xr, input logic xrdy);
        repeat (cnt) begin
            step();
            cyc_chk(n0, h0, b0, n1, h1, b1, xr, xrdy);
        end
    endtask

    initial begin
        rst = 1'b0; en = 2'b00; cfg_valid = 1'b0; div_cfg = '0;
        step(); step();
        chk_v("rst_clk_out", clk_out, 2'b00);
        chk_v("rst_tick", tick, 2'b00);
        chk_v("rst_rst_out", rst_out, 2'b00);
        chk_v("rst_cfg_ready", cfg_ready, 1'b1);
        chk_v("clk_cpy", clk_cpy, 1'b1);

        rst = 1'b1;
        step();
        chk_v("park_clk_out", clk_out, 2'b00);
        chk_v("park_tick", tick, 2'b00);

        // Default ratio 13 on both channels, rst_out after the 7th tick.
        en = 2'b11;
        step();
        a = cyc;
        cyc_chk(13, H13, a, 13, H13, a, 2'b00, 1'b1);
        for (int r = 1; r < 94; r++) begin
            step();
            cyc_chk(13, H13, a, 13, H13, a, (r >= 79) ? 2'b11 : 2'b00, 1'b1);
        end

        // Mid-period reconfiguration to 4/7; a second request while busy is dropped.
        div_cfg = {8'd7, 8'd4};
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        cyc_chk(13, H13, a, 13, H13, a, 2'b11, 1'b0);
        run(2, 13, H13, a, 13, H13, a, 2'b11, 1'b0);
        div_cfg = {8'd9, 8'd9};
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        cyc_chk(13, H13, a, 13, H13, a, 2'b11, 1'b0);
        run(6, 13, H13, a, 13, H13, a, 2'b11, 1'b0);
        run(28, 4, 2, a + 104, 7, H7, a + 104, 2'b11, 1'b1);

        // Ratios 0 and 1 behave as divide-by-2.
        div_cfg = {8'd1, 8'd0};
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        cyc_chk(4, 2, a + 104, 7, H7, a + 104, 2'b11, 1'b0);
        run(3, 4, 2, a + 104, 7, H7, a + 104, 2'b11, 1'b0);
        run(3, 2, 1, a + 136, 7, H7, a + 104, 2'b11, 1'b0);
        run(12, 2, 1, a + 136, 2, 1, a + 139, 2'b11, 1'b1);

        // Asynchronous reset while clk_out[0] is high.
        #2;
        rst = 1'b0;
        #1;
        chk_v("async_clk_out", clk_out, 2'b00);
        chk_v("async_tick", tick, 2'b00);
        chk_v("async_rst_out", rst_out, 2'b00);
        chk_v("async_cfg_ready", cfg_ready, 1'b1);
        step();
        rst = 1'b1;
        step();
        b3 = cyc;
        cyc_chk(13, H13, b3, 13, H13, b3, 2'b00, 1'b1);
        for (int r = 1; r < 95; r++) begin
            step();
            cyc_chk(13, H13, b3, 13, H13, b3, (r >= 79) ? 2'b11 : 2'b00, 1'b1);
        end

        // Drop en[0] three cycles into the high phase, then restart it.
        en = 2'b10;
        run(9, 13, H13, b3, 13, H13, b3, 2'b11, 1'b1);
        run(6, 0, 0, 0, 13, H13, b3, 2'b11, 1'b1);
        en = 2'b11;
        run(16, 13, H13, b3 + 110, 13, H13, b3, 2'b11, 1'b1);

        // Odd ratio 5 on both channels.
        div_cfg = {8'd5, 8'd5};
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        cyc_chk(13, H13, b3 + 110, 13, H13, b3, 2'b11, 1'b0);
        run(3, 13, H13, b3 + 110, 13, H13, b3, 2'b11, 1'b0);
        run(6, 13, H13, b3 + 110, 5, H5, b3 + 130, 2'b11, 1'b0);
        run(20, 5, H5, b3 + 136, 5, H5, b3 + 130, 2'b11, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
